udma_stream_tx_arbiter: RTL and testbench



---
 rtl/udma_stream_arb_pkg.sv | 23 ++
 rtl/udma_stream_arb_tag_fifo.sv | 52 +++++
 rtl/udma_stream_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_udma_stream_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_stream_arb_pkg.sv
// Shared types and helpers for the uDMA stream tx arbiter.
// Holds the datasize encoding, tag-width helper and count type.
package udma_stream_arb_pkg;

  // L2 transfer size encoding carried on the datasize ports
  typedef enum logic [1:0] {
    DS_BYTE = 2'b00,
    DS_HALF = 2'b01,
    DS_WORD = 2'b10
  } datasize_e;

  // Widest outstanding-read depth the count type can represent
  localparam int unsigned ARB_MAX_OUTSTANDING = 128;

  // Count type sized for the widest supported tag FIFO (depth plus one state)
  typedef logic [$clog2(ARB_MAX_OUTSTANDING):0] arb_cnt_t;

  // Bits needed to name one of n_streams requesters (at least 1)
  function automatic int unsigned tag_width(input int unsigned n_streams);
    return (n_streams <= 2) ? 1 : $clog2(n_streams);
  endfunction

endpackage

// File: rtl/udma_stream_arb_tag_fifo.sv
// Tag FIFO: records which stream unit was granted each issued read so the
// in-order responses can be routed back. Head is read combinationally.
module udma_stream_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 2,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] in_tag,
  output logic [TW-1:0] head_tag,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head_tag = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // Pointer and occupancy tracking; clr takes priority over push/pop
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage; no reset needed as entries are only read when valid
  always_ff @(posedge clk_i) begin
    if (push && !clr) mem[wr_ptr] <= in_tag;
  end

endmodule

// File: rtl/udma_stream_tx_arbiter.sv
// Shares one L2 tx read channel between N_STREAMS stream units.
// Round-robin address arbitration; a tag FIFO routes in-order responses.
// Define UDMA_STREAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module udma_stream_tx_arbiter
  import udma_stream_arb_pkg::*;
#(
  parameter int unsigned N_STREAMS      = 4,
  parameter int unsigned L2_AWIDTH_NOAL = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OUTSTANDING    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clr_i,
  input  logic [N_STREAMS-1:0]                req_i,
  input  logic [N_STREAMS*L2_AWIDTH_NOAL-1:0] addr_i,
  input  logic [N_STREAMS*2-1:0]              datasize_i,
  output logic [N_STREAMS-1:0]                gnt_o,
  output logic [N_STREAMS-1:0]                valid_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  input  logic [N_STREAMS-1:0]                ready_i,
  output logic                                tx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]           tx_ch_addr_o,
  output logic [1:0]                          tx_ch_datasize_o,
  input  logic                                tx_ch_gnt_i,
  input  logic                                tx_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]               tx_ch_data_i,
  output logic                                tx_ch_ready_o,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned TW = tag_width(N_STREAMS);
  localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

  logic [TW-1:0] sel;
  logic          found;
  int unsigned   scan_start;
  int unsigned   scan_idx;
  logic          any_req;
  logic          grant;
  logic          pop;
  logic          full;
  logic          empty;
  logic [TW-1:0] head_tag;
  logic [CW-1:0] count;

`ifndef UDMA_STREAM_ARB_FIXED_PRIO_EN
  logic [TW-1:0] r_prio;
`endif

  // Pick the first requester at or after the priority pointer (wrapping)
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = 0;
`ifdef UDMA_STREAM_ARB_FIXED_PRIO_EN
    scan_start = 0;
`else
    scan_start = int'(r_prio);
`endif
    for (int unsigned i = 0; i < N_STREAMS; i++) begin
      scan_idx = (scan_start + i) % N_STREAMS;
      if (!found && req_i[scan_idx]) begin
        found = 1'b1;
        sel   = TW'(scan_idx);
      end
    end
  end

  assign any_req     = |req_i;
  assign tx_ch_req_o = any_req & ~full;
  assign grant       = tx_ch_req_o & tx_ch_gnt_i;

  // Forward the selected unit's address/size and raise its grant
  always_comb begin
    tx_ch_addr_o     = '0;
    tx_ch_datasize_o = '0;
    gnt_o            = '0;
    if (any_req) begin
      tx_ch_addr_o     = addr_i[sel*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
      tx_ch_datasize_o = datasize_i[sel*2 +: 2];
    end
    if (grant) gnt_o[sel] = 1'b1;
  end

  // Route the response to the unit at the FIFO head; orphans are absorbed
  always_comb begin
    valid_o       = '0;
    tx_ch_ready_o = 1'b1;
    pop           = 1'b0;
    if (!empty) begin
      valid_o[head_tag] = tx_ch_valid_i;
      tx_ch_ready_o     = ready_i[head_tag];
      pop               = tx_ch_valid_i & ready_i[head_tag];
    end
  end

  assign data_o = tx_ch_data_i;
  assign busy_o = (count != '0);

`ifndef UDMA_STREAM_ARB_FIXED_PRIO_EN
  // Advance the priority pointer past the unit just granted
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_prio <= '0;
    end else if (grant) begin
      r_prio <= (sel == TW'(N_STREAMS - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

  // Sticky error on a response arriving with no outstanding tag
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      err_o <= 1'b0;
    end else if (empty && tx_ch_valid_i) begin
      err_o <= 1'b1;
    end
  end

  udma_stream_arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .TW    (TW),
    .CW    (CW)
  ) u_tag_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (clr_i),
    .push     (grant),
    .pop      (pop),
    .in_tag   (sel),
    .head_tag (head_tag),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: tb/tb_udma_stream_tx_arbiter.sv
// Self-checking bench for udma_stream_tx_arbiter: directed scenarios followed
// by randomized traffic against a queue-based reference model.
module tb_udma_stream_tx_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned OUT = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              clr_i;
  logic [N-1:0]      req_i;
  logic [N*AW-1:0]   addr_i;
  logic [N*2-1:0]    datasize_i;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      valid_o;
  logic [DW-1:0]     data_o;
  logic [N-1:0]      ready_i;
  logic              tx_ch_req_o;
  logic [AW-1:0]     tx_ch_addr_o;
  logic [1:0]        tx_ch_datasize_o;
  logic              tx_ch_gnt_i;
  logic              tx_ch_valid_i;
  logic [DW-1:0]     tx_ch_data_i;
  logic              tx_ch_ready_o;
  logic              busy_o;
  logic              err_o;

  always #5 clk = ~clk;

  udma_stream_tx_arbiter #(
    .N_STREAMS      (N),
    .L2_AWIDTH_NOAL (AW),
    .DATA_WIDTH     (DW),
    .OUTSTANDING    (OUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .clr_i            (clr_i),
    .req_i            (req_i),
    .addr_i           (addr_i),
    .datasize_i       (datasize_i),
    .gnt_o            (gnt_o),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .ready_i          (ready_i),
    .tx_ch_req_o      (tx_ch_req_o),
    .tx_ch_addr_o     (tx_ch_addr_o),
    .tx_ch_datasize_o (tx_ch_datasize_o),
    .tx_ch_gnt_i      (tx_ch_gnt_i),
    .tx_ch_valid_i    (tx_ch_valid_i),
    .tx_ch_data_i     (tx_ch_data_i),
    .tx_ch_ready_o    (tx_ch_ready_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] addr_a [N];
  logic [1:0]    ds_a   [N];
  int            prio;
  int            q[$];
  bit            m_err;

  // Outputs captured in the last cycle for scenario-level checks
  logic [N-1:0]  obs_gnt;
  logic [N-1:0]  obs_valid;
  logic          obs_req;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic vld,
                       input logic [DW-1:0] dat, input logic [N-1:0] rdy, input logic clr);
    req_i         = req;
    tx_ch_gnt_i   = gnt;
    tx_ch_valid_i = vld;
    tx_ch_data_i  = dat;
    ready_i       = rdy;
    clr_i         = clr;
    for (int k = 0; k < N; k++) begin
      addr_i[k*AW +: AW]   = addr_a[k];
      datasize_i[k*2 +: 2] = ds_a[k];
    end
  endtask

  // Check all outputs against the model, then advance the model at the edge
  task automatic cycle();
    int           s;
    int           idx;
    int           h;
    bit           found;
    bit           full;
    bit           ereq;
    logic [N-1:0] egnt;
    logic [N-1:0] evalid;
    logic         erdy;
    #1;
    full  = (q.size() == OUT);
    s     = 0;
    found = 0;
    for (int i = 0; i < N; i++) begin
      idx = (prio + i) % N;
      if (!found && req_i[idx]) begin
        found = 1;
        s     = idx;
      end
    end
    ereq = found && !full;
    egnt = '0;
    if (ereq && tx_ch_gnt_i) egnt[s] = 1'b1;
    evalid = '0;
    erdy   = 1'b1;
    h      = 0;
    if (q.size() != 0) begin
      h         = q[0];
      evalid[h] = tx_ch_valid_i;
      erdy      = ready_i[h];
    end
    check("tx_req",   64'(tx_ch_req_o),      64'(ereq));
    check("gnt",      64'(gnt_o),            64'(egnt));
    check("addr",     64'(tx_ch_addr_o),     found ? 64'(addr_a[s]) : 64'd0);
    check("datasize", 64'(tx_ch_datasize_o), found ? 64'(ds_a[s]) : 64'd0);
    check("valid",    64'(valid_o),          64'(evalid));
    check("ch_ready", 64'(tx_ch_ready_o),    64'(erdy));
    check("data",     64'(data_o),           64'(tx_ch_data_i));
    check("busy",     64'(busy_o),           64'(q.size() != 0));
    check("err",      64'(err_o),            64'(m_err));
    obs_gnt   = gnt_o;
    obs_valid = valid_o;
    obs_req   = tx_ch_req_o;
    @(posedge clk);
    if (clr_i) begin
      q.delete();
      prio  = 0;
      m_err = 0;
    end else begin
      if (q.size() != 0) begin
        if (tx_ch_valid_i && ready_i[h]) void'(q.pop_front());
      end else if (tx_ch_valid_i) begin
        m_err = 1;
      end
      if (ereq && tx_ch_gnt_i) begin
        q.push_back(s);
`ifndef UDMA_STREAM_ARB_FIXED_PRIO_EN
        prio = (s + 1) % N;
`endif
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      addr_a[k] = AW'(k << 8);
      ds_a[k]   = 2'(k % 3);
    end
    rst_i = 1'b1;
    drive('0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    prio  = 0;
    m_err = 0;
    q.delete();

    // Reset state
    cycle();

    // Four back-to-back grants fill the tag FIFO
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 1'b1, 1'b0, '0, '0, 1'b0);
      cycle();
`ifdef UDMA_STREAM_ARB_FIXED_PRIO_EN
      check("grant_order", 64'(obs_gnt), 64'd1);
`else
      check("grant_order", 64'(obs_gnt), 64'(1 << c));
`endif
    end
    drive(4'b1111, 1'b1, 1'b0, '0, '0, 1'b0);
    cycle();
    check("full_blocks_req", 64'(obs_req), 64'd0);

    // Full FIFO: pop with a pending request does not unblock this cycle
    drive(4'b1000, 1'b1, 1'b1, 32'h5555_0000, 4'b1111, 1'b0);
    cycle();
    check("full_pop_no_gnt", 64'(obs_gnt), 64'd0);
    drive(4'b1000, 1'b1, 1'b0, '0, '0, 1'b0);
    cycle();
    check("gnt_after_pop", 64'(obs_gnt), 64'b1000);

    // Drain with data 0xA0..0xA3
    for (int c = 0; c < 4; c++) begin
      drive('0, 1'b0, 1'b1, DW'(32'hA0 + c), 4'b1111, 1'b0);
      cycle();
    end
    drive('0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();

    // Back-pressure on the head unit holds the response
    drive(4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);
    cycle();
    repeat (3) begin
      drive('0, 1'b0, 1'b1, 32'h1234_5678, 4'b1011, 1'b0);
      cycle();
    end
    drive('0, 1'b0, 1'b1, 32'h1234_5678, 4'b0100, 1'b0);
    cycle();

    // Rotating priority with two requesters
    drive(4'b0001, 1'b1, 1'b0, '0, '0, 1'b0);
    cycle();
    drive('0, 1'b0, 1'b1, 32'hBEEF, 4'b1111, 1'b0);
    cycle();
    repeat (2) begin
      drive(4'b0101, 1'b1, 1'b0, '0, '0, 1'b0);
      cycle();
    end
    repeat (2) begin
      drive('0, 1'b0, 1'b1, 32'hCAFE, 4'b1111, 1'b0);
      cycle();
    end

    // Orphan response sets err_o; clr_i clears it
    drive('0, 1'b0, 1'b1, 32'hDEAD, '0, 1'b0);
    cycle();
    drive('0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();
    check("orphan_err", 64'(err_o), 64'd1);
    drive('0, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle();
    drive('0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        addr_a[k] = AW'($urandom);
        ds_a[k]   = 2'($urandom_range(0, 2));
      end
      drive(N'($urandom), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            DW'($urandom), N'($urandom), ($urandom_range(0, 63) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
